// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a two-entry skid buffer (main + skid) and a branch-taken pulse.
// Optional forwarding outputs are compiled in when the FWD_EN macro is defined.
module ex_mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic            in_zero_flag,
  input  logic [4:0]      in_rd,
  input  logic [3:0]      in_ctrl,
  input  logic [XLEN-1:0] in_store_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_alu_result,
  output logic [4:0]      out_rd,
  output logic [3:0]      out_ctrl,
  output logic [XLEN-1:0] out_store_data,
  output logic            branch_taken
`ifdef FWD_EN
  ,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data
`endif
);

  // _p0 holds the skid entry, _p1 the main entry that drives the memory stage
  logic            vld_p0;
  logic [XLEN-1:0] alu_result_p0;
  logic [4:0]      rd_p0;
  logic [3:0]      ctrl_p0;
  logic [XLEN-1:0] store_data_p0;

  logic            vld_p1;
  logic [XLEN-1:0] alu_result_p1;
  logic [4:0]      rd_p1;
  logic [3:0]      ctrl_p1;
  logic [XLEN-1:0] store_data_p1;

  logic acc;
  logic rel;

  assign acc = in_valid && in_ready;
  assign rel = vld_p1 && out_ready;

  // Skid / main stage boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0        <= 1'b0;
      vld_p1        <= 1'b0;
      in_ready      <= 1'b1;
      branch_taken  <= 1'b0;
      alu_result_p0 <= '0;
      rd_p0         <= '0;
      ctrl_p0       <= '0;
      store_data_p0 <= '0;
      alu_result_p1 <= '0;
      rd_p1         <= '0;
      ctrl_p1       <= '0;
      store_data_p1 <= '0;
    end else if (flush) begin
      vld_p0       <= 1'b0;
      vld_p1       <= 1'b0;
      in_ready     <= 1'b1;
      branch_taken <= 1'b0;
    end else begin
      branch_taken <= acc && in_ctrl[0] && in_zero_flag;
      // in_ready low implies skid occupied, so a drain with a full skid never coincides with accept
      if (rel && vld_p0) begin
        alu_result_p1 <= alu_result_p0;
        rd_p1         <= rd_p0;
        ctrl_p1       <= ctrl_p0;
        store_data_p1 <= store_data_p0;
        vld_p0        <= 1'b0;
        in_ready      <= 1'b1;
      end else if (acc && (!vld_p1 || rel)) begin
        alu_result_p1 <= in_alu_result;
        rd_p1         <= in_rd;
        ctrl_p1       <= in_ctrl;
        store_data_p1 <= in_store_data;
        vld_p1        <= 1'b1;
      end else if (acc) begin
        alu_result_p0 <= in_alu_result;
        rd_p0         <= in_rd;
        ctrl_p0       <= in_ctrl;
        store_data_p0 <= in_store_data;
        vld_p0        <= 1'b1;
        in_ready      <= 1'b0;
      end else if (rel) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid      = vld_p1;
  assign out_alu_result = alu_result_p1;
  assign out_rd         = rd_p1;
  assign out_ctrl       = ctrl_p1;
  assign out_store_data = store_data_p1;

`ifdef FWD_EN
  assign fwd_valid = vld_p1 && ctrl_p1[3] && (rd_p1 != 5'd0);
  assign fwd_rd    = rd_p1;
  assign fwd_data  = alu_result_p1;
`endif

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of result and store data.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  execute stage presents an entry.
REQ-005 SHALL have port in_ready  output  1  stage can accept an entry this cycle.
REQ-006 SHALL have port in_alu_result  input  XLEN  ALU result.
REQ-007 SHALL have port in_zero_flag  input  1  ALU zero flag.
REQ-008 SHALL have port in_rd  input  5  destination register index.
REQ-009 SHALL have port in_ctrl  input  4  {reg_write, mem_read, mem_write, branch}, MSB first.
REQ-010 SHALL have port in_store_data  input  XLEN  rs2 value for stores.
REQ-011 SHALL have port flush  input  1  discard all held entries.
REQ-012 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_alu_result (output, XLEN), out_rd (output, 5), out_ctrl (output, 4), out_store_data (output, XLEN) toward memory stage.
REQ-013 SHALL have port branch_taken  output  1  one-cycle pulse: accepted branch entry had zero flag set.

Function
REQ-014 SHALL hold up to two entries: main register (drives out_*) and skid register.
REQ-015 SHALL accept an entry when in_valid && in_ready; SHALL release one when out_valid && out_ready.
REQ-016 SHALL drive in_ready as a registered signal, high iff skid register empty.
REQ-017 SHALL present an accepted entry on out_* the cycle after acceptance when main was empty or drained that cycle (latency 1).
REQ-018 SHALL write the incoming entry to skid when main is occupied and not draining; on the next drain, skid SHALL move to main.
REQ-019 SHALL preserve strict FIFO order; no entry lost or duplicated under any valid/ready pattern.
REQ-020 SHALL keep out_* stable while out_valid && !out_ready.
REQ-021 SHALL, on simultaneous accept and release with skid empty, load incoming entry directly into main.
REQ-022 SHALL assert branch_taken for exactly one cycle, the cycle after accepting an entry with branch=1 and in_zero_flag=1; otherwise 0.
REQ-023 SHALL, on flush, clear both entries at the next edge (out_valid=0, in_ready=1), ignore any same-cycle input, and suppress branch_taken.
REQ-024 SHALL ignore in_* data when in_valid=0 and SHALL not drop an in_valid entry while in_ready=0 (upstream holds).

Reset
REQ-025 SHALL, while rst_n=0, force out_valid=0, in_ready=1, branch_taken=0, out_alu_result=0, out_rd=0, out_ctrl=0, out_store_data=0, skid empty.
REQ-026 SHALL discard any held entries when reset asserts mid-operation; first accept possible on first edge after rst_n rises.

Configuration
REQ-027 SHALL, with FWD_EN defined, add outputs fwd_valid (1), fwd_rd (5), fwd_data (XLEN) equal to out_valid && out_ctrl[3] && out_rd!=0, out_rd, out_alu_result, all 0 in reset.
REQ-028 SHALL, without FWD_EN, omit fwd_* ports entirely with no other behavioural change.

Verification
REQ-029 SHALL cover: reset release, in_valid=1 result 0x0000_0010 rd=5 ctrl=1000, out_ready=1 -> out_valid=1 next cycle with same values, in_ready stays 1.
REQ-030 SHALL cover: out_ready=0, three back-to-back entries A,B,C -> A in main, B in skid, in_ready=0 holds C; raise out_ready -> A,B,C in order, one per cycle.
REQ-031 SHALL cover: branch entry ctrl=0001 with zero_flag=1 -> branch_taken=1 one cycle; same with zero_flag=0 -> branch_taken stays 0.
REQ-032 SHALL cover: both entries full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, incoming entry not emitted.
REQ-033 SHALL cover: rst_n pulled low asynchronously mid-stream -> all outputs 0, in_ready=1 before next clock edge.
REQ-034 SHALL cover (FWD_EN): entry rd=0 reg_write=1 -> fwd_valid=0; rd=7 result 0xDEAD_BEEF -> fwd_valid=1, fwd_rd=7, fwd_data=0xDEAD_BEEF.
